btb_upd_arbiter: RTL and testbench

- Shares the single BTB update port between two branch-resolution sources: port 0 (conditional branch unit) and port 1 (jump unit, JAL/JALR).
- Accepts up to two resolutions per cycle into a small in-order update FIFO. Drains one entry per cycle onto the BTB write interface.
- Sequences BTB flushes: drops queued updates, pulses the BTB flush, then inserts a recovery bubble.
- Sits between the execute-stage resolution logic and the BTB.

---
 rtl/mmm_pkg.sv | 19 +
 rtl/btb_upd_fifo.sv | 98 +++++++++
 rtl/btb_upd_arbiter.sv | 107 ++++++++++
 tb/tb_btb_upd_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared predictor definitions: datapath width, BTB update record and FSM
// state encoding for the BTB update arbiter.
package mmm_pkg;

   localparam int XLEN               = 32;
   localparam int BTB_UPD_FIFO_DEPTH = 4;

   typedef struct packed {
      logic            del;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
   } btb_upd_t;

   typedef enum logic {
      ARB_RUN   = 1'b0,
      ARB_FLUSH = 1'b1
   } btb_arb_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Dual-push / single-pop in-order FIFO of BTB updates with synchronous clear.
// With BTB_UPD_MERGE_EN defined, pushes matching the youngest PC merge in place.
module btb_upd_fifo
   import mmm_pkg::*;
#(
   parameter  int DEPTH = BTB_UPD_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             push0_i,
   input  btb_upd_t         push0_data_i,
   input  logic             push1_i,
   input  btb_upd_t         push1_data_i,
   input  logic             pop_i,
   output btb_upd_t         head_o,
   output logic [CNT_W-1:0] count_o
);

   btb_upd_t         mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             alloc0, alloc1;
   logic [PTR_W-1:0] wr0_idx, wr1_idx;
   logic [1:0]       n_alloc;
`ifdef BTB_UPD_MERGE_EN
   logic             merge_ok;
   logic [PTR_W-1:0] youngest;
`endif

   always_comb begin
      alloc0  = push0_i;
      alloc1  = push1_i;
      wr0_idx = wr_ptr_q;
      wr1_idx = wr_ptr_q + PTR_W'(push0_i);
`ifdef BTB_UPD_MERGE_EN
      // The head leaving this cycle is not a merge candidate.
      merge_ok = (count_q != '0) && !(pop_i && (count_q == CNT_W'(1)));
      youngest = wr_ptr_q - PTR_W'(1);
      if (push0_i && merge_ok && (mem_q[youngest].pc == push0_data_i.pc)) begin
         alloc0  = 1'b0;
         wr0_idx = youngest;
      end
      if (push1_i) begin
         if (push0_i) begin
            if (push1_data_i.pc == push0_data_i.pc) begin
               alloc1  = 1'b0;
               wr1_idx = wr0_idx;
            end else begin
               wr1_idx = wr_ptr_q + PTR_W'(alloc0);
            end
         end else if (merge_ok && (mem_q[youngest].pc == push1_data_i.pc)) begin
            alloc1  = 1'b0;
            wr1_idx = youngest;
         end
      end
`endif
      n_alloc = {1'b0, alloc0} + {1'b0, alloc1};
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
         wr_ptr_d = wr_ptr_q + PTR_W'(n_alloc);
         count_d  = count_q + CNT_W'(n_alloc) - CNT_W'(pop_i);
      end
   end

   // NOTE: storage is reset so the BTB data outputs read 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q <= '{default: '0};
      end else if (!clear_i) begin
         if (push0_i) mem_q[wr0_idx] <= push0_data_i;
         if (push1_i) mem_q[wr1_idx] <= push1_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/btb_upd_arbiter.sv
// Shares the BTB update port between the branch unit (port 0) and jump unit
// (port 1); sequences flushes. Optional in-place merge: BTB_UPD_MERGE_EN.
module btb_upd_arbiter
   import mmm_pkg::*;
#(
   parameter int UPD_FIFO_DEPTH = BTB_UPD_FIFO_DEPTH
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [1:0]           req_del_i,
   input  logic [1:0][XLEN-1:0] req_pc_i,
   input  logic [1:0][XLEN-1:0] req_target_i,
   output logic                 btb_update_valid_o,
   output logic                 btb_del_entry_o,
   output logic [XLEN-1:0]      btb_res_pc_o,
   output logic [XLEN-1:0]      btb_res_target_o,
   output logic                 btb_flush_o,
   output logic                 busy_o
);

   localparam int CNT_W = $clog2(UPD_FIFO_DEPTH) + 1;

   btb_arb_state_e   state_q, state_d;
   logic             rr_q, rr_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] free;
   logic             pop;
   logic [1:0]       ready, xfer;
   logic             first_push, second_push;
   btb_upd_t         first_data, second_data, head;
   btb_upd_t         req_upd [2];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         req_upd[p] = '{del: req_del_i[p], pc: req_pc_i[p], target: req_target_i[p]};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_RUN:   if (flush_i)  state_d = ARB_FLUSH;
         ARB_FLUSH: if (!flush_i) state_d = ARB_RUN;
         default:   state_d = ARB_RUN;
      endcase

      pop  = (count != '0) && (state_q == ARB_RUN) && !flush_i;
      free = CNT_W'(UPD_FIFO_DEPTH) - count + CNT_W'(pop);

      // Ready is a function of occupancy and rr_q only, never of req_valid_i.
      ready = 2'b00;
      if ((state_q == ARB_RUN) && !flush_i) begin
         if (free >= CNT_W'(2))     ready = 2'b11;
         else if (free == CNT_W'(1)) ready[rr_q] = 1'b1;
      end
      xfer = req_valid_i & ready;

      first_push  = 1'b0;
      second_push = 1'b0;
      first_data  = req_upd[rr_q];
      second_data = req_upd[~rr_q];
      if (xfer[rr_q]) begin
         first_push  = 1'b1;
         second_push = xfer[~rr_q];
      end else if (xfer[~rr_q]) begin
         first_push = 1'b1;
         first_data = req_upd[~rr_q];
      end
      rr_d = rr_q ^ xfer[rr_q];
   end

   // NOTE: state registers use non-blocking assignment; all decode lives in always_comb.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ARB_RUN;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   btb_upd_fifo #(.DEPTH(UPD_FIFO_DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clear_i      (flush_i),
      .push0_i      (first_push),
      .push0_data_i (first_data),
      .push1_i      (second_push),
      .push1_data_i (second_data),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (count)
   );

   assign req_ready_o        = ready;
   assign btb_update_valid_o = pop;
   assign btb_del_entry_o    = head.del;
   assign btb_res_pc_o       = head.pc;
   assign btb_res_target_o   = head.target;
   assign btb_flush_o        = flush_i;
   assign busy_o             = (count != '0) || (state_q == ARB_FLUSH);

endmodule

// File: tb/tb_btb_upd_arbiter.sv
// Self-checking bench for btb_upd_arbiter: queue-based reference model and
// scoreboard, a vector table of single updates, and directed flush/merge/reset runs.
module tb_btb_upd_arbiter;
   import mmm_pkg::*;

   localparam int DEPTH = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_n_i;
   logic                 flush_i;
   logic [1:0]           req_valid_i;
   logic [1:0]           req_ready_o;
   logic [1:0]           req_del_i;
   logic [1:0][XLEN-1:0] req_pc_i;
   logic [1:0][XLEN-1:0] req_target_i;
   logic                 btb_update_valid_o;
   logic                 btb_del_entry_o;
   logic [XLEN-1:0]      btb_res_pc_o;
   logic [XLEN-1:0]      btb_res_target_o;
   logic                 btb_flush_o;
   logic                 busy_o;

   btb_upd_arbiter #(.UPD_FIFO_DEPTH(DEPTH)) dut (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .flush_i            (flush_i),
      .req_valid_i        (req_valid_i),
      .req_ready_o        (req_ready_o),
      .req_del_i          (req_del_i),
      .req_pc_i           (req_pc_i),
      .req_target_i       (req_target_i),
      .btb_update_valid_o (btb_update_valid_o),
      .btb_del_entry_o    (btb_del_entry_o),
      .btb_res_pc_o       (btb_res_pc_o),
      .btb_res_target_o   (btb_res_target_o),
      .btb_flush_o        (btb_flush_o),
      .busy_o             (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   btb_upd_t mq [$];
   bit       m_rr;
   bit       m_fl;
   int       drained_400;

   typedef struct {
      int              port;
      bit              del;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] tgt;
      bit              exp_del;
      logic [XLEN-1:0] exp_pc;
      logic [XLEN-1:0] exp_tgt;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush_i      = 1'b0;
      req_valid_i  = 2'b00;
      req_del_i    = 2'b00;
      req_pc_i     = '0;
      req_target_i = '0;
   endtask

   task automatic set_req(input int p, input bit del, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] tgt);
      req_valid_i[p]  = 1'b1;
      req_del_i[p]    = del;
      req_pc_i[p]     = pc;
      req_target_i[p] = tgt;
   endtask

   task automatic model_push(input int p);
      btb_upd_t e;
      e = '{del: req_del_i[p], pc: req_pc_i[p], target: req_target_i[p]};
`ifdef BTB_UPD_MERGE_EN
      if (mq.size() > 0 && mq[$].pc == e.pc) mq[$] = e;
      else mq.push_back(e);
`else
      mq.push_back(e);
`endif
   endtask

   // One clock: compare at the falling edge, advance the model, clear inputs.
   task automatic step();
      bit       exp_pop;
      int       free;
      bit [1:0] exp_rdy, xfer;
      bit       first;
      @(negedge clk_i);
      exp_pop = (mq.size() != 0) && !m_fl && !flush_i;
      free    = DEPTH - mq.size() + int'(exp_pop);
      exp_rdy = 2'b00;
      if (!m_fl && !flush_i) begin
         if (free >= 2)      exp_rdy = 2'b11;
         else if (free == 1) exp_rdy[m_rr] = 1'b1;
      end
      check("req_ready", req_ready_o, exp_rdy);
      check("upd_valid", btb_update_valid_o, exp_pop);
      check("btb_flush", btb_flush_o, flush_i);
      check("busy", busy_o, (mq.size() != 0) || m_fl);
      if (exp_pop) begin
         check("upd_del", btb_del_entry_o, mq[0].del);
         check("upd_pc", btb_res_pc_o, mq[0].pc);
         check("upd_tgt", btb_res_target_o, mq[0].target);
      end
      if (btb_update_valid_o && btb_res_pc_o == 32'h400) drained_400++;
      check("fifo_bound", 64'(mq.size() <= DEPTH), 64'd1);

      xfer = req_valid_i & exp_rdy;
      if (flush_i) begin
         mq.delete();
         m_fl = 1'b1;
      end else if (m_fl) begin
         m_fl = 1'b0;
      end else begin
         if (exp_pop) void'(mq.pop_front());
         first = m_rr;
         if (xfer[first])  model_push(int'(first));
         if (xfer[!first]) model_push(int'(!first));
         if (xfer[m_rr])   m_rr = !m_rr;
      end
      @(posedge clk_i);
      #1;
      idle_inputs();
   endtask

   initial begin
      vecs[0] = '{port: 1, del: 1'b1, pc: 32'h300, tgt: 32'h0,    exp_del: 1'b1, exp_pc: 32'h300, exp_tgt: 32'h0};
      vecs[1] = '{port: 0, del: 1'b0, pc: 32'h104, tgt: 32'h2a0,  exp_del: 1'b0, exp_pc: 32'h104, exp_tgt: 32'h2a0};
      vecs[2] = '{port: 1, del: 1'b0, pc: 32'hffff_fffc, tgt: 32'h8000_0000,
                  exp_del: 1'b0, exp_pc: 32'hffff_fffc, exp_tgt: 32'h8000_0000};
      vecs[3] = '{port: 0, del: 1'b1, pc: 32'h0,   tgt: 32'hdead_beec, exp_del: 1'b1, exp_pc: 32'h0, exp_tgt: 32'hdead_beec};
      vecs[4] = '{port: 1, del: 1'b0, pc: 32'h5a5a_5a58, tgt: 32'ha5a5_a5a4,
                  exp_del: 1'b0, exp_pc: 32'h5a5a_5a58, exp_tgt: 32'ha5a5_a5a4};

      idle_inputs();
      rst_n_i = 1'b0;
      m_rr = 1'b0;
      m_fl = 1'b0;
      drained_400 = 0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", req_ready_o, 2'b11);
      check("rst_valid", btb_update_valid_o, 1'b0);
      check("rst_flush", btb_flush_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_del", btb_del_entry_o, 1'b0);
      check("rst_pc", btb_res_pc_o, '0);
      check("rst_tgt", btb_res_target_o, '0);
      rst_n_i = 1'b1;

      // Single push: appears the next cycle, idle again the cycle after.
      set_req(0, 1'b0, 32'h100, 32'h200);
      step();
      check("t1_valid_c2", btb_update_valid_o, 1'b1);
      check("t1_pc_c2", btb_res_pc_o, 32'h100);
      check("t1_tgt_c2", btb_res_target_o, 32'h200);
      step();
      check("t1_busy_c3", busy_o, 1'b0);
      step();

      for (int i = 0; i < 5; i++) begin
         set_req(vecs[i].port, vecs[i].del, vecs[i].pc, vecs[i].tgt);
         step();
         check("vec_valid", btb_update_valid_o, 1'b1);
         check("vec_del", btb_del_entry_o, vecs[i].exp_del);
         check("vec_pc", btb_res_pc_o, vecs[i].exp_pc);
         check("vec_tgt", btb_res_target_o, vecs[i].exp_tgt);
         step();
      end

      // Saturation: both ports every cycle; ready falls to rr-only once full.
      for (int k = 0; k < 12; k++) begin
         set_req(0, 1'b0, 32'h10 + 32'(2 * k), 32'h1000 + 32'(k));
         set_req(1, 1'b0, 32'h11 + 32'(2 * k), 32'h2000 + 32'(k));
         step();
      end
      repeat (6) step();

      // Flush with three entries queued, held for two cycles, then the bubble.
      set_req(0, 1'b0, 32'h700, 32'h710);
      set_req(1, 1'b0, 32'h704, 32'h714);
      step();
      set_req(0, 1'b0, 32'h708, 32'h718);
      set_req(1, 1'b0, 32'h70c, 32'h71c);
      step();
      for (int c = 0; c < 2; c++) begin
         flush_i = 1'b1;
         set_req(0, 1'b0, 32'h7f0, 32'h7f4);
         step();
      end
      set_req(1, 1'b0, 32'h7f8, 32'h7fc);
      step();
      check("t3_ready_after_bubble", req_ready_o, 2'b11);
      check("t3_busy_after_bubble", busy_o, 1'b0);
      repeat (2) step();

      // Same PC pushed twice while queued behind other entries.
      drained_400 = 0;
      set_req(0, 1'b0, 32'h800, 32'h810);
      set_req(1, 1'b0, 32'h804, 32'h814);
      step();
      set_req(0, 1'b0, 32'h400, 32'h500);
      step();
      set_req(0, 1'b0, 32'h400, 32'h600);
      step();
      repeat (5) step();
`ifdef BTB_UPD_MERGE_EN
      check("t6_drained_400", 64'(drained_400), 64'd1);
`else
      check("t6_drained_400", 64'(drained_400), 64'd2);
`endif

      // Asynchronous reset with entries queued.
      set_req(0, 1'b0, 32'h900, 32'h910);
      set_req(1, 1'b0, 32'h904, 32'h914);
      step();
      set_req(0, 1'b0, 32'h908, 32'h918);
      set_req(1, 1'b0, 32'h90c, 32'h91c);
      step();
      #2;
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_valid", btb_update_valid_o, 1'b0);
      check("mid_rst_busy", busy_o, 1'b0);
      check("mid_rst_ready", req_ready_o, 2'b11);
      mq.delete();
      m_rr = 1'b0;
      m_fl = 1'b0;
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (3) step();
      set_req(1, 1'b0, 32'ha00, 32'ha10);
      step();
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
